// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the core
// load/store port (requester 0) and the loader/debug port (requester 1).
// Round-robin grant with burst hold and a forced hand-over after
// MAX_BURST beats when the other side is waiting.
// Optional build macro DMEM_ARB_STATS_EN adds per-requester beat counters
// and a waiting-cycle counter; arbitration is identical either way.
module dmem_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 16,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          sys_rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]   beats0,
   output logic [15:0]   beats1,
   output logic [15:0]   wait_cyc
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_G0   = 2'd1,
      ST_G1   = 2'd2
   } state_t;

   // Counter only needs to reach MAX_BURST; it saturates there.
   localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

   // Saturating increment of the burst counter.
   function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] v);
      if (v >= CNT_MAX) begin
         return CNT_MAX;
      end
      return v + CW'(1);
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            last_q, last_d;     // 1 = requester 1 was granted last
   logic            rvalid0_q, rvalid0_d;
   logic            rvalid1_q, rvalid1_d;
   logic [DW-1:0]   rhold0_q, rhold0_d;
   logic [DW-1:0]   rhold1_q, rhold1_d;

   logic            beat0;
   logic            beat1;
   logic [CW-1:0]   cnt_inc;

   assign gnt0  = (state_q == ST_G0);
   assign gnt1  = (state_q == ST_G1);
   assign beat0 = req0 && gnt0;
   assign beat1 = req1 && gnt1;
   assign cnt_inc = cnt_sat_inc(cnt_q);

   // Memory port mux: driven from the beating requester, all zero otherwise.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (beat0) begin
         mem_en    = 1'b1;
         mem_we    = we0;
         mem_addr  = addr0;
         mem_wdata = wdata0;
      end else if (beat1) begin
         mem_en    = 1'b1;
         mem_we    = we1;
         mem_addr  = addr1;
         mem_wdata = wdata1;
      end
   end

   // Next-state, burst count and last-granted pointer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (req0 && req1) begin
               state_d = last_q ? ST_G0 : ST_G1;
            end else if (req0) begin
               state_d = ST_G0;
            end else if (req1) begin
               state_d = ST_G1;
            end
         end
         ST_G0: begin
            if (!req0) begin
               cnt_d   = '0;
               state_d = req1 ? ST_G1 : ST_IDLE;
            end else if (req1 && (cnt_inc == CNT_MAX)) begin
               cnt_d   = '0;
               state_d = ST_G1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_G1: begin
            if (!req1) begin
               cnt_d   = '0;
               state_d = req0 ? ST_G0 : ST_IDLE;
            end else if (req0 && (cnt_inc == CNT_MAX)) begin
               cnt_d   = '0;
               state_d = ST_G0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      // Pointer follows every fresh entry into a grant state.
      if ((state_d == ST_G0) && (state_q != ST_G0)) begin
         last_d = 1'b0;
      end else if ((state_d == ST_G1) && (state_q != ST_G1)) begin
         last_d = 1'b1;
      end
   end

   // Read return: rvalid follows a read beat by one cycle and is tied to the
   // requester that issued the beat, even if the grant has since moved on.
   always_comb begin
      rvalid0_d = beat0 && !we0;
      rvalid1_d = beat1 && !we1;
      rhold0_d  = rvalid0_q ? mem_rdata : rhold0_q;
      rhold1_d  = rvalid1_q ? mem_rdata : rhold1_q;
   end

   // Memory data arrives in the rvalid cycle itself, so it is forwarded
   // directly then and held from the capture register afterwards.
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rvalid0_q ? mem_rdata : rhold0_q;
   assign rdata1  = rvalid1_q ? mem_rdata : rhold1_q;

   // Arbiter and read-return state registers.
   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rhold0_q  <= '0;
         rhold1_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rhold0_q  <= rhold0_d;
         rhold1_q  <= rhold1_d;
      end
   end

   // Only one beat per cycle exists, so two read returns cannot coincide.
   a_rvalid_onehot: assert property (@(posedge clk) disable iff (!sys_rst)
      !(rvalid0_q && rvalid1_q));

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] beats0_q, beats0_d;
   logic [15:0] beats1_q, beats1_d;
   logic [15:0] wait_cyc_q, wait_cyc_d;

   // Saturating 16-bit increment for the waiting-cycle counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Beat counters wrap; waiting counter saturates, one count per cycle.
   always_comb begin
      beats0_d   = beat0 ? beats0_q + 16'd1 : beats0_q;
      beats1_d   = beat1 ? beats1_q + 16'd1 : beats1_q;
      wait_cyc_d = wait_cyc_q;
      if ((req0 && !gnt0) || (req1 && !gnt1)) begin
         wait_cyc_d = sat_inc16(wait_cyc_q);
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         beats0_q   <= '0;
         beats1_q   <= '0;
         wait_cyc_q <= '0;
      end else begin
         beats0_q   <= beats0_d;
         beats1_q   <= beats1_d;
         wait_cyc_q <= wait_cyc_d;
      end
   end

   assign beats0   = beats0_q;
   assign beats1   = beats1_q;
   assign wait_cyc = wait_cyc_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed phases plus randomized traffic, checked
// by a queue-based scoreboard fed from a rule-level reference model.
module tb_dmem_arbiter;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          sys_rst = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
   logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0]   beats0, beats1, wait_cyc;
`endif

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .sys_rst(sys_rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      , .beats0(beats0), .beats1(beats1), .wait_cyc(wait_cyc)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int i);
      return (i == 3) ? 16'h001F : 16'((i * 257) ^ 16'h5A5A);
   endfunction

   // Synchronous single-port memory: read data valid the cycle after mem_en.
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rd_q = '0;
   logic          preload = 1'b1;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        rd_q <= mem[mem_addr];
      end
   end
   assign mem_rdata = rd_q;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic          g0, g1, en, we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } cyc_t;
   typedef struct {
      int            who;
      logic [DW-1:0] d;
      int            due;
   } rd_t;

   cyc_t          exp_cyc[$];
   rd_t           exp_rd[$];
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] last_rd [2];
   int            owner = -1;   // -1: nobody granted
   int            run   = 0;    // beats taken in the current grant
   int            last  = 1;
   int            vectors = 0, miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner = -1; run = 0; last = 1;
      exp_cyc.delete(); exp_rd.delete();
      last_rd[0] = '0; last_rd[1] = '0;
   endtask

   // Reference: who owns the memory this cycle, what access results, and
   // who owns it next, straight from the arbitration rules.
   task automatic model_step();
      cyc_t e;
      bit   rq [2];
      int   nxt;
      rq[0] = req0; rq[1] = req1;
      e = '{default: '0};
      e.g0 = (owner == 0);
      e.g1 = (owner == 1);
      if (owner >= 0 && rq[owner]) begin
         e.en = 1'b1;
         e.we = (owner == 1) ? we1 : we0;
         e.a  = (owner == 1) ? addr1 : addr0;
         e.d  = (owner == 1) ? wdata1 : wdata0;
         if (e.we) ref_mem[e.a] = e.d;
         else exp_rd.push_back('{owner, ref_mem[e.a], cyc + 1});
      end
      exp_cyc.push_back(e);
      if (owner < 0) begin
         run = 0;
         if (rq[0] && rq[1]) nxt = 1 - last;
         else if (rq[0])     nxt = 0;
         else if (rq[1])     nxt = 1;
         else                nxt = -1;
      end else if (!rq[owner]) begin
         run = 0;
         nxt = rq[1 - owner] ? 1 - owner : -1;
      end else begin
         run++;
         if (rq[1 - owner] && run >= MB) begin
            nxt = 1 - owner;
            run = 0;
         end else begin
            nxt = owner;
         end
      end
      if (nxt >= 0 && nxt != owner) last = nxt;
      owner = nxt;
   endtask

   // Called at posedge+1: apply inputs, then predict this cycle.
   task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input logic r1, input logic w1,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      #1;
      if (sys_rst) model_step();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic r1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      drive(r0, w0, a0, d0, r1, w1, a1, d1);
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   task automatic both_read(input int n);
      for (int i = 0; i < n; i++)
         step(1, 0, AW'($urandom_range(0, 255)), '0, 1, 0, AW'($urandom_range(0, 255)), '0);
   endtask

   // Monitor: pops one cycle expectation per cycle and read returns on rvalid.
   always @(negedge clk) begin : mon
      cyc_t e;
      rd_t  r;
      if (sys_rst) begin
         if (exp_cyc.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL cycle_expectation: none queued at t=%0t", $time);
         end else begin
            e = exp_cyc.pop_front();
            chk("gnt", 32'({gnt0, gnt1}), 32'({e.g0, e.g1}));
            chk("mem_en", 32'(mem_en), 32'(e.en));
            chk("mem_bus", 32'({mem_we, mem_addr, mem_wdata}), 32'({e.we, e.a, e.d}));
         end
         if (rvalid0 || rvalid1) begin
            if (exp_rd.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL rvalid_unexpected: rvalid=%b%b expected none", rvalid0, rvalid1);
            end else begin
               r = exp_rd.pop_front();
               chk("rvalid_who", 32'({rvalid0, rvalid1}), (r.who == 0) ? 32'h2 : 32'h1);
               chk("rdata", 32'((r.who == 1) ? rdata1 : rdata0), 32'(r.d));
               chk("rd_latency", 32'(cyc), 32'(r.due));
               last_rd[r.who] = r.d;
            end
         end else if (exp_rd.size() > 0 && exp_rd[0].due <= cyc) begin
            r = exp_rd.pop_front();
            vectors++; miscompares++;
            $display("FAIL rvalid_missing: got none expected requester %0d data %0h", r.who, r.d);
         end
         if (!rvalid0) chk("rdata0_hold", 32'(rdata0), 32'(last_rd[0]));
         if (!rvalid1) chk("rdata1_hold", 32'(rdata1), 32'(last_rd[1]));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic          r0, r1, w0, w1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      model_reset();

      // Reset held with both requesting.
      req0 = 1; req1 = 1;
      repeat (2) @(posedge clk);
      #1 preload = 1'b0;
      chk("reset_gnt", 32'({gnt0, gnt1}), 32'h0);
      chk("reset_mem_en", 32'(mem_en), 32'h0);
      chk("reset_rvalid", 32'({rvalid0, rvalid1}), 32'h0);
      chk("reset_rdata", 32'({rdata0, rdata1}), 32'h0);
      tick();
      sys_rst = 1'b1;
      drive(1, 0, 8'h01, '0, 1, 0, 8'h02, '0);
      tick();
      chk("first_grant_r0", 32'({gnt0, gnt1}), 32'h2);
      idle(3);

      // Single read of address 3 by requester 0.
      step(1, 0, 8'h03, '0, 0, 0, '0, '0);
      step(1, 0, 8'h03, '0, 0, 0, '0, '0);
      idle(3);

      // Requester 1 writes 0xBEEF to 0x10, then reads it back.
      step(0, 0, '0, '0, 1, 1, 8'h10, 16'hBEEF);
      step(0, 0, '0, '0, 1, 1, 8'h10, 16'hBEEF);
      step(0, 0, '0, '0, 1, 0, 8'h10, '0);
      idle(3);

      // Sustained contention.
      both_read(40);
      idle(3);

      // Requester 0 drops after two beats while requester 1 waits.
      both_read(3);
      drive(0, 0, '0, '0, 1, 0, 8'h20, '0);
      tick();
      chk("early_release_gnt1", 32'({gnt0, gnt1}), 32'h1);
      idle(3);

      // Requester 1 alone for 10 read beats.
      for (int i = 0; i < 11; i++) step(0, 0, '0, '0, 1, 0, AW'(i), '0);
      idle(3);

      // Randomized mixed traffic on a small address window.
      for (int i = 0; i < 800; i++) begin
         r0 = ($urandom_range(0, 3) != 0);
         r1 = ($urandom_range(0, 3) != 0);
         w0 = 1'($urandom_range(0, 1));
         w1 = 1'($urandom_range(0, 1));
         a0 = AW'($urandom_range(0, 31));
         a1 = AW'($urandom_range(0, 31));
         d0 = DW'($urandom);
         d1 = DW'($urandom);
         step(r0, w0, a0, d0, r1, w1, a1, d1);
      end
      idle(3);

      // Reset asserted during the second beat of a requester-1 burst.
      step(0, 0, '0, '0, 1, 0, 8'h04, '0);
      step(0, 0, '0, '0, 1, 0, 8'h05, '0);
      drive(0, 0, '0, '0, 1, 0, 8'h06, '0);
      #1 sys_rst = 1'b0;
      #1;
      chk("midrst_gnt", 32'({gnt0, gnt1}), 32'h0);
      chk("midrst_mem_en", 32'(mem_en), 32'h0);
      chk("midrst_rvalid1", 32'(rvalid1), 32'h0);
      model_reset();
      req0 = 1; req1 = 1;
      tick();
      tick();
      sys_rst = 1'b1;
      drive(1, 0, 8'h07, '0, 1, 0, 8'h08, '0);
      tick();
      chk("post_reset_gnt0", 32'({gnt0, gnt1}), 32'h2);
      both_read(16);
`ifdef DMEM_ARB_STATS_EN
      chk("stats_beats_sum", 32'(beats0) + 32'(beats1), 32'd16);
      chk("stats_wait_nz", 32'(wait_cyc != 16'd0), 32'd1);
`endif
      idle(3);

      drive(0, 0, '0, '0, 0, 0, '0, '0);
      @(negedge clk);
      #1;
      chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
